// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
// The master side issues requests; the slave side answers with ack and read data.
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory access per request, with lane steering,
// load extension, and misalignment / illegal-funct3 / ack-timeout reporting.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal,
    output logic        o_bus_err,
    lsu_if.master       mem_if
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_misaligned;
    logic        r_illegal;
    logic        r_bus_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_timeout;

    // Request decode on the raw inputs, used only in the accept cycle.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_wstrb      = 4'b0000;
        w_wdata      = i_wdata;
        if (i_is_store) begin
            w_illegal = (i_funct3[2] == 1'b1) || (i_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (i_funct3[1:0] == 2'b11) || (i_funct3[2:1] == 2'b11);
        end
        unique case (i_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = i_addr[0];
                w_wstrb      = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = (i_addr[1:0] != 2'b00);
                w_wstrb      = 4'b1111;
            end
            default: begin
                w_wstrb = 4'b0000;
            end
        endcase
    end

    // Load lane selection and extension from the acknowledged word.
    always_comb begin
        w_shifted = mem_if.mem_rdata >> {r_addr_lo, 3'b000};
        w_half    = r_addr_lo[1] ? mem_if.mem_rdata[31:16] : mem_if.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h000000, w_shifted[7:0]};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = mem_if.mem_rdata;
        endcase
    end

    // r_cnt counts WAIT cycles already elapsed without ack.
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_addr_lo    <= 2'b00;
            r_funct3     <= 3'b000;
            r_is_store   <= 1'b0;
            r_done       <= 1'b0;
            r_rdata      <= 32'h0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_bus_err    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wstrb  <= 4'b0000;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_addr_lo  <= i_addr[1:0];
                        r_funct3   <= i_funct3;
                        r_is_store <= i_is_store;
                        if (w_illegal) begin
                            r_state   <= StDone;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                            r_rdata   <= 32'h0;
                        end else if (w_misaligned) begin
                            r_state      <= StDone;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_rdata      <= 32'h0;
                        end else begin
                            r_state     <= StWait;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_is_store;
                            r_mem_addr  <= {i_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= i_is_store ? w_wstrb : 4'b0000;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (mem_if.mem_ack) begin
                        r_state     <= StDone;
                        r_done      <= 1'b1;
                        r_rdata     <= r_is_store ? 32'h0 : w_load;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                    end else if (w_timeout) begin
                        r_state     <= StDone;
                        r_done      <= 1'b1;
                        r_bus_err   <= 1'b1;
                        r_rdata     <= 32'h0;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_illegal    <= 1'b0;
                    r_bus_err    <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready          = (r_state == StIdle);
    assign o_done           = r_done;
    assign o_rdata          = r_rdata;
    assign o_misaligned     = r_misaligned;
    assign o_illegal        = r_illegal;
    assign o_bus_err        = r_bus_err;
    assign mem_if.mem_req   = r_mem_req;
    assign mem_if.mem_we    = r_mem_we;
    assign mem_if.mem_addr  = r_mem_addr;
    assign mem_if.mem_wdata = r_mem_wdata;
    assign mem_if.mem_wstrb = r_mem_wstrb;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit in the execute/memory boundary, directly downstream of the ALU. It takes the effective address from the ALU result, plus rs2 data and funct3, and performs one data-memory access over a req/ack bus. It generates byte strobes, lane-replicated write data and sign/zero-extended load results. It also reports misalignment, illegal funct3 and bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles o_mem_req waits for i_mem_ack before abort; 0 disables the timeout.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  request valid from execute stage
o_ready  output  1  unit idle, can accept a request
i_addr  input  32  effective address (ALU o_alu_data)
i_wdata  input  32  store data (rs2)
i_funct3  input  3  RV32I load/store funct3
i_is_store  input  1  1 = store, 0 = load
o_done  output  1  one-cycle completion pulse
o_rdata  output  32  extended load result, valid when o_done
o_misaligned  output  1  alignment fault, valid when o_done
o_illegal  output  1  unsupported funct3, valid when o_done
o_bus_err  output  1  ack timeout, valid when o_done
o_mem_req  output  1  memory request
o_mem_we  output  1  memory write enable
o_mem_addr  output  32  word address, bits [1:0] = 0
o_mem_wdata  output  32  lane-replicated store data
o_mem_wstrb  output  4  byte strobes, 0000 for loads
i_mem_ack  input  1  memory acknowledge
i_mem_rdata  input  32  read word, valid with i_mem_ack

Behaviour:
- FSM states: IDLE, WAIT, DONE. o_ready = (state == IDLE).
- Accept: i_valid && o_ready, at cycle N. addr, wdata, funct3 and is_store are registered at accept.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Precedence at accept: illegal -> DONE with o_illegal=1. Else misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with o_misaligned=1. No memory request is issued in either case.
- Legal and aligned -> WAIT. o_mem_req=1 from cycle N+1 and held stable until ack. o_mem_addr, o_mem_we, o_mem_wdata and o_mem_wstrb are also held stable.
- Store strobes:
  - byte: 0001 << addr[1:0], wdata[7:0] replicated x4.
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata[15:0] replicated x2.
  - word: 1111, wdata unchanged.
- Ack is sampled in every WAIT cycle; the earliest ack is at N+1. On ack: o_mem_req drops the next cycle, go to DONE.
- Load extraction: select byte or half by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- DONE: o_done=1 for exactly one cycle, then IDLE.
  - Normal latency: o_done at ack cycle + 1, i.e. N+2 minimum.
  - Fault latency: o_done at N+1.
- o_rdata is registered and updated only on transition into DONE. It is 0 for stores and faults, and holds its value otherwise.
- Timeout: a counter resets on entry to WAIT and increments each WAIT cycle without ack. When TIMEOUT_CYCLES > 0 and the count reaches TIMEOUT_CYCLES with no ack: drop req, go to DONE with o_bus_err=1 and o_rdata=0. Ack and timeout in the same cycle: ack wins.
- Error flags are 0 whenever o_done=0.
- i_valid while not ready is ignored; the requester must hold it.
- Reset, async, any state: state=IDLE, and all outputs 0 except o_ready=1. An in-flight req drops immediately, and a late ack after reset is ignored.

Test Plan:
- LW addr 0x100, ack on first WAIT cycle with rdata 0xDEADBEEF -> o_mem_addr 0x100, wstrb 0000, o_done at N+2, o_rdata 0xDEADBEEF.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80xxxxxx -> o_rdata 0xFFFFFF80 and 0x00000080 respectively; LH addr 0x102, rdata 0x8001xxxx -> 0xFFFF8001.
- SB addr 0x201, wdata 0x12345678 -> o_mem_addr 0x200, wstrb 0010, wdata 0x78787878; SH addr 0x202 -> wstrb 1100, wdata 0x56785678; ack delayed 5 cycles -> outputs stable throughout.
- LW addr 0x102 -> o_done at N+1, o_misaligned=1, no o_mem_req. Store with funct3 100 -> o_illegal=1, no req.
- TIMEOUT_CYCLES=4, no ack -> req high 4 cycles, then o_done with o_bus_err=1. Ack on the 4th cycle instead -> normal completion.
- Assert i_rst_n low during WAIT -> o_mem_req drops asynchronously and o_ready=1. A following ack produces no o_done.
